// File: rtl/muldiv_sequencer_if.sv
// Handshake bundle between the EX stage and the iterative mul/div engine.
// Latency: none (wires only).
// Backpressure: engine drives stall = start & ~result_valid; EX holds start/operands while stalled.
//   start, op, left_operand, right_operand, flush : EX stage -> engine
//   busy, stall, result_valid, result             : engine -> EX stage
interface muldiv_sequencer_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  start;
  logic [2:0]            op;
  logic [DATA_WIDTH-1:0] left_operand;
  logic [DATA_WIDTH-1:0] right_operand;
  logic                  flush;
  logic                  busy;
  logic                  stall;
  logic                  result_valid;
  logic [DATA_WIDTH-1:0] result;

  // Pipeline (EX stage) side.
  modport master (
    output start, op, left_operand, right_operand, flush,
    input  busy, stall, result_valid, result
  );

  // Engine side.
  modport slave (
    input  start, op, left_operand, right_operand, flush,
    output busy, stall, result_valid, result
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide engine: one shared shift-add / restoring-subtract datapath.
// Latency: accept at edge k -> result_valid high after edge k+DATA_WIDTH+1; divide special cases after edge k+1.
// Backpressure: stall = start & ~result_valid freezes IF/ID/EX; flush aborts anything short of DONE.
//   clk, rst (sync, active-low) are plain ports; everything else travels on the muldiv_sequencer_if slave modport.
//   busy = FSM not idle, result is registered and holds until the next result_valid pulse.
module muldiv_sequencer #(
  parameter int DATA_WIDTH = 32
) (
  input logic               clk,
  input logic               rst,
  muldiv_sequencer_if.slave bus
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;

  localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } state_t;

  state_t         state;
  logic [CW-1:0]  cnt;
  logic [2:0]     op_q;
  logic [2*W-1:0] acc;         // {product hi, product lo} or {remainder, quotient}
  logic [W-1:0]   a_sh;        // multiplier (shifts right) or dividend (shifts left)
  logic [W-1:0]   b_mag;       // multiplicand or divisor magnitude
  logic           neg_q;       // product / quotient must be negated
  logic           neg_rem_q;   // remainder must be negated
  logic           special_q;
  logic [W-1:0]   spec_val_q;
  logic           result_valid_q;
  logic [W-1:0]   result_q;

  // ---------------------------------------------------------------------------
  // Accept-time decode: operand magnitudes, sign flags and special-case bypass.
  // ---------------------------------------------------------------------------
  logic         a_signed;
  logic         b_signed;
  logic         a_neg;
  logic         b_neg;
  logic [W-1:0] a_mag;
  logic [W-1:0] b_mag_in;
  logic         is_div;
  logic         div_zero;
  logic         div_ovf;
  logic         special;
  logic [W-1:0] spec_val;

  // MUL is treated as signed x signed: the low word is identical either way.
  assign a_signed = (bus.op == OP_MUL) || (bus.op == OP_MULH) || (bus.op == OP_MULHSU) ||
                    (bus.op == OP_DIV) || (bus.op == OP_REM);
  assign b_signed = (bus.op == OP_MUL) || (bus.op == OP_MULH) ||
                    (bus.op == OP_DIV) || (bus.op == OP_REM);

  assign a_neg    = a_signed & bus.left_operand[W-1];
  assign b_neg    = b_signed & bus.right_operand[W-1];
  // Negating the most-negative value yields the same bit pattern, which is the
  // correct unsigned magnitude 2^(W-1).
  assign a_mag    = a_neg ? -bus.left_operand  : bus.left_operand;
  assign b_mag_in = b_neg ? -bus.right_operand : bus.right_operand;

  assign is_div   = bus.op[2];
  assign div_zero = is_div && (bus.right_operand == '0);
  assign div_ovf  = ((bus.op == OP_DIV) || (bus.op == OP_REM)) &&
                    (bus.left_operand == MOST_NEG) && (bus.right_operand == '1);
  assign special  = div_zero || div_ovf;

  // op[1] separates remainder ops (REM/REMU) from quotient ops (DIV/DIVU).
  always_comb begin
    spec_val = '0;
    if (div_zero) begin
      spec_val = bus.op[1] ? bus.left_operand : '1;
    end else if (div_ovf) begin
      spec_val = bus.op[1] ? '0 : MOST_NEG;
    end
  end

  // ---------------------------------------------------------------------------
  // One iteration of the shared datapath.
  // ---------------------------------------------------------------------------
  logic [W:0] mul_sum;
  logic [W:0] rem_sh;
  logic [W:0] div_diff;
  logic       borrow;

  assign mul_sum  = {1'b0, acc[2*W-1:W]} + (a_sh[0] ? {1'b0, b_mag} : '0);
  assign rem_sh   = {acc[2*W-1:W], a_sh[W-1]};
  assign div_diff = rem_sh - {1'b0, b_mag};
  // The partial remainder is always below the divisor, so the shifted value is
  // below twice the divisor and the top bit of the difference is the borrow.
  assign borrow   = div_diff[W];

  // ---------------------------------------------------------------------------
  // Sign fix-up and word select.
  // ---------------------------------------------------------------------------
  logic [2*W-1:0] prod_fix;
  logic [W-1:0]   quo;
  logic [W-1:0]   rem;
  logic [W-1:0]   fix_val;

  assign prod_fix = neg_q ? -acc : acc;
  assign quo      = acc[W-1:0];
  assign rem      = acc[2*W-1:W];

  always_comb begin
    fix_val = '0;
    if (special_q) begin
      fix_val = spec_val_q;
    end else begin
      case (op_q)
        OP_MUL:                       fix_val = prod_fix[W-1:0];
        OP_MULH, OP_MULHSU, OP_MULHU: fix_val = prod_fix[2*W-1:W];
        OP_DIV, OP_DIVU:              fix_val = neg_q ? -quo : quo;
        default:                      fix_val = neg_rem_q ? -rem : rem;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Controller and datapath registers.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      state          <= S_IDLE;
      cnt            <= '0;
      op_q           <= '0;
      acc            <= '0;
      a_sh           <= '0;
      b_mag          <= '0;
      neg_q          <= 1'b0;
      neg_rem_q      <= 1'b0;
      special_q      <= 1'b0;
      spec_val_q     <= '0;
      result_valid_q <= 1'b0;
      result_q       <= '0;
    end else begin
      result_valid_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start && !bus.flush) begin
            op_q       <= bus.op;
            acc        <= '0;
            a_sh       <= a_mag;
            b_mag      <= b_mag_in;
            neg_q      <= a_neg ^ b_neg;
            neg_rem_q  <= a_neg;
            special_q  <= special;
            spec_val_q <= spec_val;
            cnt        <= '0;
            state      <= special ? S_FIX : S_CALC;
          end
        end

        S_CALC: begin
          if (bus.flush) begin
            state <= S_IDLE;
          end else begin
            if (!op_q[2]) begin
              acc  <= {mul_sum, acc[W-1:1]};
              a_sh <= a_sh >> 1;
            end else begin
              acc  <= {(borrow ? rem_sh[W-1:0] : div_diff[W-1:0]), acc[W-2:0], ~borrow};
              a_sh <= a_sh << 1;
            end
            cnt <= cnt + CW'(1);
            if (cnt == LAST) begin
              state <= S_FIX;
            end
          end
        end

        S_FIX: begin
          if (bus.flush) begin
            state <= S_IDLE;
          end else begin
            result_q       <= fix_val;
            result_valid_q <= 1'b1;
            state          <= S_DONE;
          end
        end

        // The pulse completes even under flush; the pipeline discards it.
        S_DONE: state <= S_IDLE;

        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy         = (state != S_IDLE);
  assign bus.stall        = bus.start & ~result_valid_q;
  assign bus.result_valid = result_valid_q;
  assign bus.result       = result_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
module tb_muldiv_sequencer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  muldiv_sequencer_if #(.DATA_WIDTH(32)) bus_if ();

  muldiv_sequencer #(.DATA_WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  localparam logic [31:0] MOST_NEG = 32'h8000_0000;
  localparam int NORMAL_LAT  = 33;  // edges from accept edge to result_valid
  localparam int SPECIAL_LAT = 1;   // accept edge then the FIX edge: valid on the 2nd edge counting accept

  int          n_pass  = 0;
  int          n_total = 0;
  logic [31:0] last_result;

  // Reference model: RV32M semantics from plain arithmetic.
  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [63:0] sa, sb, ua, ub, p;
    int si, sj;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'b0, a};
    ub = {32'b0, b};
    si = a;
    sj = b;
    case (op)
      3'd0: begin p = sa * sb; return p[31:0];  end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == MOST_NEG && b == 32'hFFFF_FFFF) return MOST_NEG;
        return 32'(si / sj);
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        return a / b;
      end
      3'd6: begin
        if (b == 0) return a;
        if (a == MOST_NEG && b == 32'hFFFF_FFFF) return 32'h0;
        return 32'(si % sj);
      end
      default: begin
        if (b == 0) return a;
        return a % b;
      end
    endcase
  endfunction

  function automatic int model_lat(input logic [2:0] op, input logic [31:0] a,
                                   input logic [31:0] b);
    if (op[2] && (b == 0 || ((op == 3'd4 || op == 3'd6) && a == MOST_NEG && b == 32'hFFFF_FFFF)))
      return SPECIAL_LAT;
    return NORMAL_LAT;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bus_if.start         = 1'b1;
    bus_if.op            = op;
    bus_if.left_operand  = a;
    bus_if.right_operand = b;
  endtask

  // Inputs must already be driven; the first edge here is the accept edge.
  // Returns positioned in the result_valid (DONE) cycle with start still high.
  task automatic expect_result(input string tag, input logic [31:0] exp, input int lat);
    int n;
    int stall_n;
    int busy_lo;
    tick();
    chk({tag, "/accept_busy"}, 32'(bus_if.busy), 32'd1);
    n = 0;
    stall_n = 0;
    busy_lo = 0;
    while (bus_if.result_valid !== 1'b1 && n < 100) begin
      if (bus_if.stall === 1'b1) stall_n++;
      if (bus_if.busy !== 1'b1) busy_lo++;
      tick();
      n++;
    end
    chk({tag, "/latency"}, n, lat);
    chk({tag, "/stall_cycles"}, stall_n, lat);
    chk({tag, "/busy_gap"}, busy_lo, 0);
    chk({tag, "/result"}, bus_if.result, exp);
    chk({tag, "/stall_in_valid"}, 32'(bus_if.stall), 32'd0);
    last_result = exp;
  endtask

  task automatic release_op(input string tag);
    bus_if.start = 1'b0;
    tick();
    chk({tag, "/pulse_one_cycle"}, 32'(bus_if.result_valid), 32'd0);
    chk({tag, "/idle_after"}, 32'(bus_if.busy), 32'd0);
  endtask

  logic [2:0]  d_op  [12] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7, 3'd5, 3'd6, 3'd4, 3'd6};
  logic [31:0] d_a   [12] = '{32'd7, MOST_NEG, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9,
                              32'hFFFF_FFF9, 32'd100, 32'd100, 32'd5, 32'd5, MOST_NEG, MOST_NEG};
  logic [31:0] d_b   [12] = '{32'hFFFF_FFFD, MOST_NEG, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2,
                              32'd2, 32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
  logic [31:0] d_exp [12] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF,
                              32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2, 32'hFFFF_FFFF,
                              32'd5, MOST_NEG, 32'd0};
  int          d_lat [12] = '{33, 33, 33, 33, 33, 33, 33, 33, 1, 1, 1, 1};

  initial begin
    logic [2:0]  r_op;
    logic [31:0] r_a, r_b;
    int          sel;
    int          vld_seen;

    rst                  = 1'b0;
    bus_if.start         = 1'b0;
    bus_if.flush         = 1'b0;
    bus_if.op            = 3'd0;
    bus_if.left_operand  = 32'd0;
    bus_if.right_operand = 32'd0;
    last_result          = 32'd0;

    // Reset state.
    tick();
    tick();
    chk("reset/busy", 32'(bus_if.busy), 32'd0);
    chk("reset/valid", 32'(bus_if.result_valid), 32'd0);
    chk("reset/result", bus_if.result, 32'd0);
    chk("reset/stall", 32'(bus_if.stall), 32'd0);
    rst = 1'b1;
    tick();

    // Directed vectors, including divide special cases.
    for (int i = 0; i < 12; i++) begin
      drive(d_op[i], d_a[i], d_b[i]);
      expect_result($sformatf("dir%0d", i), d_exp[i], d_lat[i]);
      release_op($sformatf("dir%0d", i));
    end

    // Flush together with start in IDLE: no accept.
    drive(3'd0, 32'd3, 32'd4);
    bus_if.flush = 1'b1;
    tick();
    chk("flush_idle/busy", 32'(bus_if.busy), 32'd0);
    bus_if.flush = 1'b0;
    bus_if.start = 1'b0;
    tick();

    // Flush in CALC cycle 10.
    drive(3'd0, 32'd12345, 32'd678);
    tick();
    repeat (10) tick();
    bus_if.flush = 1'b1;
    tick();
    bus_if.flush = 1'b0;
    bus_if.start = 1'b0;
    chk("flush_calc/busy", 32'(bus_if.busy), 32'd0);
    chk("flush_calc/valid", 32'(bus_if.result_valid), 32'd0);
    chk("flush_calc/result", bus_if.result, last_result);
    vld_seen = 0;
    repeat (40) begin
      tick();
      if (bus_if.result_valid === 1'b1) vld_seen++;
    end
    chk("flush_calc/no_pulse", vld_seen, 0);
    chk("flush_calc/result_held", bus_if.result, last_result);
    drive(3'd5, 32'd9, 32'd3);
    expect_result("after_flush_divu", 32'd3, NORMAL_LAT);
    release_op("after_flush_divu");

    // Back-to-back MUL, MUL: one bubble cycle in IDLE, then accept.
    drive(3'd0, 32'd1000, 32'd2000);
    expect_result("b2b_first", model(3'd0, 32'd1000, 32'd2000), NORMAL_LAT);
    drive(3'd0, 32'hFFFF_FF00, 32'd77);
    tick();
    chk("b2b/bubble_busy", 32'(bus_if.busy), 32'd0);
    chk("b2b/bubble_valid", 32'(bus_if.result_valid), 32'd0);
    chk("b2b/bubble_stall", 32'(bus_if.stall), 32'd1);
    expect_result("b2b_second", model(3'd0, 32'hFFFF_FF00, 32'd77), NORMAL_LAT);
    release_op("b2b_second");

    // Reset in CALC cycle 20 overrides everything.
    drive(3'd1, 32'h1234_5678, 32'h9ABC_DEF0);
    tick();
    repeat (20) tick();
    rst = 1'b0;
    bus_if.start = 1'b0;
    tick();
    chk("reset_mid/busy", 32'(bus_if.busy), 32'd0);
    chk("reset_mid/valid", 32'(bus_if.result_valid), 32'd0);
    chk("reset_mid/result", bus_if.result, 32'd0);
    chk("reset_mid/stall", 32'(bus_if.stall), 32'd0);
    rst = 1'b1;
    last_result = 32'd0;
    tick();

    // Randomized operations against the reference model.
    for (int i = 0; i < 24; i++) begin
      r_op = 3'($urandom_range(0, 7));
      r_a  = $urandom;
      r_b  = $urandom;
      sel  = $urandom_range(0, 7);
      if (sel == 0) r_b = 32'd0;
      if (sel == 1) begin
        r_a = MOST_NEG;
        r_b = 32'hFFFF_FFFF;
      end
      if (sel == 2) r_b = 32'($urandom_range(1, 15));
      if (sel == 3) r_a = 32'($urandom_range(0, 255));
      drive(r_op, r_a, r_b);
      expect_result($sformatf("rnd%0d_op%0d", i, r_op), model(r_op, r_a, r_b),
                    model_lat(r_op, r_a, r_b));
      release_op($sformatf("rnd%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Iterative RV32M multiply/divide engine and its controller, placed beside the ALU in the execute stage.
- When EX holds an M-extension instruction, the pipeline drives `start` with the already-forwarded operands (after the forwarding mux).
- The block raises `stall` until the result is ready, then presents the result for one cycle for the EX-stage output mux.
- One shared shift-add/restoring-subtract datapath serves all eight ops. The block owns the FSM, iteration counter, sign handling and special-case bypass.

Parameters:
- DATA_WIDTH, 32, operand/result width. ITER = DATA_WIDTH iterations. Counter width is clog2(DATA_WIDTH).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-low reset.
- start  in  1  EX holds a mul/div instruction. Level; held by the pipeline while stalled.
- op  in  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- left_operand  in  DATA_WIDTH  rs1 value (forwarded).
- right_operand  in  DATA_WIDTH  rs2 value (forwarded).
- flush  in  1  branch_taken/kill of the EX instruction. Aborts the operation.
- busy  out  1  FSM not IDLE.
- stall  out  1  start & ~result_valid (combinational). Freezes IF/ID/EX.
- result_valid  out  1  one-cycle pulse; result is valid.
- result  out  DATA_WIDTH  registered result; holds its value until the next result_valid.

Behaviour:
- Reset (rst=0 at an edge): state=IDLE, counter=0, busy=0, result_valid=0, result=0. Overrides all other inputs, including in mid-operation.
- States: IDLE, CALC, FIX, DONE.
- IDLE, start=1 and flush=0:
  - Latch op.
  - Latch operand magnitudes: signed ops take the absolute value of signed inputs. MULHSU treats only rs1 as signed.
  - Latch the result-sign flags. Division: quotient sign = a[31]^b[31]; remainder sign = a[31].
  - Clear the 2*DATA_WIDTH accumulator and set counter=0.
  - Next state is CALC, or FIX directly on a special case.
- Special cases, detected at accept:
  - Divisor=0: DIV/DIVU give all-ones; REM/REMU give the dividend.
  - DIV with 0x8000_0000 / 0xFFFF_FFFF: quotient 0x8000_0000, REM gives 0.
  - These skip CALC, so result_valid follows 2 edges after accept.
- CALC, one bit per cycle, counter increments each cycle:
  - Multiply: shift-add on the 64-bit {product, multiplier}.
  - Divide: restoring shift-subtract on {remainder, quotient}.
  - When counter = DATA_WIDTH-1 the next state is FIX.
- FIX:
  - Apply two's-complement negation to the 64-bit product or the 32-bit quotient/remainder per the sign flags.
  - Select the low word (MUL, quotient/remainder) or the high word (MULH*).
  - Register result and assert result_valid for the next cycle. Next state is DONE.
- DONE: result_valid=1 for exactly one cycle; next state is IDLE.
- Latency: accept at edge k means result_valid is high in the cycle after edge k+DATA_WIDTH+1 (k+33 for 32 bits). busy is high from edge k until edge k+DATA_WIDTH+2.
- start while not IDLE: ignored, with no re-accept. Pipeline contract: `start` stays asserted with stable operands until result_valid.
- DONE-cycle behaviour: stall drops, EX advances.
  - A new mul/div entering EX on the next cycle is accepted from IDLE.
  - Back-to-back ops therefore pay one bubble cycle (DONE to IDLE).
- flush=1 in any state other than DONE: next state is IDLE, no result_valid, result unchanged.
- flush in DONE: the pulse still completes. The pipeline discards it.
- flush together with start in IDLE: no accept.
- Width rules:
  - All internal arithmetic is DATA_WIDTH+1 bits for subtract (borrow) and 2*DATA_WIDTH bits for the product.
  - No X-propagation: the datapath is registered from reset.

Test Plan:
- MUL 7 x -3 (0x0000_0007, 0xFFFF_FFFD) -> result 0xFFFF_FFEB; result_valid exactly 33 edges after accept; stall high 33 cycles.
- MULH 0x8000_0000 x 0x8000_0000 -> 0x4000_0000. MULHU 0xFFFF_FFFF x 0xFFFF_FFFF -> 0xFFFF_FFFE. MULHSU 0xFFFF_FFFF x 0xFFFF_FFFF -> 0xFFFF_FFFF.
- DIV -7/2 -> 0xFFFF_FFFD. REM -7/2 -> 0xFFFF_FFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2.
- DIVU 5/0 -> 0xFFFF_FFFF and REM 5/0 -> 5. DIV 0x8000_0000/0xFFFF_FFFF -> 0x8000_0000. Each valid 2 edges after accept.
- Accept MUL, pulse flush at CALC cycle 10 -> IDLE next edge, no result_valid, result unchanged. Then start DIVU 9/3 -> 3 with full latency.
- rst=0 asserted in CALC cycle 20 -> all outputs 0 next edge. Back-to-back MUL,MUL -> second accept one cycle after the first result_valid.
